// File: rtl/lbp_pkg.sv
// Shared types and helpers for the LBP raster-scan controller.
// A fetch index walks the 3x3 window column-major: idx = col*3 + row.
package lbp_pkg;

    localparam int DEF_IMG_W = 128;
    localparam int DEF_IMG_H = 128;
    localparam int DEF_AW    = 14;

    typedef enum logic [2:0] {IDLE, FILL, SLIDE, EMIT, DONE} state_t;

    // Window slots, row-major; p4 is the centre pixel
    localparam logic [3:0] SLOT_P0 = 4'd0;
    localparam logic [3:0] SLOT_P1 = 4'd1;
    localparam logic [3:0] SLOT_P2 = 4'd2;
    localparam logic [3:0] SLOT_P3 = 4'd3;
    localparam logic [3:0] SLOT_P4 = 4'd4;
    localparam logic [3:0] SLOT_P5 = 4'd5;
    localparam logic [3:0] SLOT_P6 = 4'd6;
    localparam logic [3:0] SLOT_P7 = 4'd7;
    localparam logic [3:0] SLOT_P8 = 4'd8;

    localparam logic [3:0] FETCH_FIRST = 4'd0;
    localparam logic [3:0] FETCH_SLIDE = 4'd6;  // right column only
    localparam logic [3:0] FETCH_DONE  = 4'd9;

    function automatic int fetch_offset(input logic [3:0] idx, input int img_w);
        int r;
        int c;
        r = int'(idx) % 3;
        c = int'(idx) / 3;
        return (r - 1) * img_w + (c - 1);
    endfunction

    function automatic logic [3:0] fetch_slot(input logic [3:0] idx);
        return 4'((int'(idx) % 3) * 3 + int'(idx) / 3);
    endfunction

endpackage

// File: rtl/lbp_win_regs.sv
// Nine-pixel window store: slot-addressed load from returning read data and a
// one-column left shift used when the window slides right.
module lbp_win_regs
    import lbp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [3:0]  load_slot,
    input  logic [7:0]  load_data,
    input  logic        shift_en,
    output logic [71:0] win
);
    logic [8:0][7:0] p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p <= '0;
        end else begin
            if (shift_en) begin
                p[SLOT_P0] <= p[SLOT_P1];
                p[SLOT_P1] <= p[SLOT_P2];
                p[SLOT_P3] <= p[SLOT_P4];
                p[SLOT_P4] <= p[SLOT_P5];
                p[SLOT_P6] <= p[SLOT_P7];
                p[SLOT_P7] <= p[SLOT_P8];
            end
            if (load_en)
                p[load_slot] <= load_data;
        end
    end

    assign win = p;

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Raster-scan controller: fetches each interior 3x3 neighbourhood from gray
// memory and hands it to the LBP compute stage, sliding along each row.
module lbp_scan_ctrl
    import lbp_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    input  logic [7:0]    gray_data,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [71:0]   win_data,
    output logic [AW-1:0] win_addr,
    output logic          busy,
    output logic          finish
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 2);

    state_t        state;
    logic [3:0]    idx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [AW-1:0] ctr;
    logic          rd_pend;
    logic [3:0]    rd_slot;
    logic          fetching;
    logic          shift_en;
    logic [AW-1:0] off;

    always_comb begin
        fetching = (state == FILL || state == SLIDE) && (idx != FETCH_DONE);
        off      = AW'(fetch_offset(idx, IMG_W));
    end

    // Request is gated combinationally so a stalled cycle never issues
    assign gray_req  = fetching && gray_ready;
    assign gray_addr = fetching ? ctr + off : '0;
    assign shift_en  = (state == EMIT) && win_ready && (col < COL_LAST);

    lbp_win_regs u_win (
        .clk       (clk),
        .reset     (reset),
        .load_en   (rd_pend),
        .load_slot (rd_slot),
        .load_data (gray_data),
        .shift_en  (shift_en),
        .win       (win_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= FETCH_FIRST;
            col       <= CW'(1);
            row       <= RW'(1);
            ctr       <= AW'(IMG_W + 1);
            rd_pend   <= 1'b0;
            rd_slot   <= '0;
            win_valid <= 1'b0;
            win_addr  <= '0;
            busy      <= 1'b0;
            finish    <= 1'b0;
        end else begin
            // Read data lands one cycle after its request, into the slot noted here
            rd_pend <= gray_req;
            rd_slot <= fetch_slot(idx);
            case (state)
                IDLE: begin
                    if (gray_ready) begin
                        state <= FILL;
                        idx   <= FETCH_FIRST;
                        busy  <= 1'b1;
                    end
                end
                FILL, SLIDE: begin
                    if (gray_req) begin
                        idx <= idx + 4'd1;
                    end else if (idx == FETCH_DONE) begin
                        state     <= EMIT;
                        win_valid <= 1'b1;
                        win_addr  <= ctr;
                    end
                end
                EMIT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (col < COL_LAST) begin
                            col   <= col + CW'(1);
                            ctr   <= ctr + AW'(1);
                            idx   <= FETCH_SLIDE;
                            state <= SLIDE;
                        end else if (row < ROW_LAST) begin
                            col   <= CW'(1);
                            row   <= row + RW'(1);
                            ctr   <= ctr + AW'(3);  // skip right border, left border
                            idx   <= FETCH_FIRST;
                            state <= FILL;
                        end else begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            finish <= 1'b1;
                        end
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Directed bench for lbp_scan_ctrl: small 5x4 frame scenarios plus a
// full default-size frame checked against a neighbourhood scoreboard.
module tb_lbp_scan_ctrl;
    localparam int AW = 14;
    localparam int SW = 5;
    localparam int SH = 4;
    localparam int BW = 128;
    localparam int BH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          s_reset, s_gready, s_req, s_wvalid, s_wready, s_busy, s_finish;
    logic [7:0]    s_gdata;
    logic [AW-1:0] s_gaddr, s_waddr;
    logic [71:0]   s_wdata;

    logic          b_reset, b_gready, b_req, b_wvalid, b_wready, b_busy, b_finish;
    logic [7:0]    b_gdata;
    logic [AW-1:0] b_gaddr, b_waddr;
    logic [71:0]   b_wdata;

    lbp_scan_ctrl #(.IMG_W(SW), .IMG_H(SH), .AW(AW)) u_small (
        .clk(clk), .reset(s_reset), .gray_ready(s_gready), .gray_data(s_gdata),
        .gray_req(s_req), .gray_addr(s_gaddr), .win_valid(s_wvalid),
        .win_ready(s_wready), .win_data(s_wdata), .win_addr(s_waddr),
        .busy(s_busy), .finish(s_finish));

    lbp_scan_ctrl #(.IMG_W(BW), .IMG_H(BH), .AW(AW)) u_big (
        .clk(clk), .reset(b_reset), .gray_ready(b_gready), .gray_data(b_gdata),
        .gray_req(b_req), .gray_addr(b_gaddr), .win_valid(b_wvalid),
        .win_ready(b_wready), .win_data(b_wdata), .win_addr(b_waddr),
        .busy(b_busy), .finish(b_finish));

    // Memories: small frame holds gray[a] = a mod 256, big frame is random
    logic [7:0] bmem [0:16383];
    always @(posedge clk) s_gdata <= s_gaddr[7:0];
    always @(posedge clk) b_gdata <= bmem[b_gaddr];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [71:0] exp_win_s(input int a);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(r*3+c) +: 8] = 8'((a + (r-1)*SW + (c-1)) % 256);
        return w;
    endfunction

    function automatic logic [71:0] exp_win_b(input int a);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(r*3+c) +: 8] = bmem[a + (r-1)*BW + (c-1)];
        return w;
    endfunction

    // Small-frame monitor, sampled on the falling edge
    int          cyc = 0;
    int          req_q[$], req_cyc[$], acc_addr[$], acc_cyc[$], vstart[$];
    logic [71:0] acc_data[$];
    int          viol = 0, stall_viol = 0, fin_cyc = -1;
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic [71:0] prev_data = '0;
    logic [AW-1:0] prev_addr = '0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!s_reset) begin
            if (s_req) begin
                req_q.push_back(int'(s_gaddr));
                req_cyc.push_back(cyc);
                if (!s_gready) viol++;
            end
            if (s_wvalid && !prev_valid) vstart.push_back(cyc);
            if (prev_valid && !prev_ready &&
                (!s_wvalid || s_req || s_wdata != prev_data || s_waddr != prev_addr))
                stall_viol++;
            if (s_wvalid && s_wready) begin
                acc_addr.push_back(int'(s_waddr));
                acc_data.push_back(s_wdata);
                acc_cyc.push_back(cyc);
            end
            if (s_finish && fin_cyc < 0) fin_cyc = cyc;
        end
        prev_valid = s_wvalid && !s_reset;
        prev_ready = s_wready;
        prev_data  = s_wdata;
        prev_addr  = s_waddr;
    end

    // Big-frame scoreboard: windows must appear in raster order
    int b_reads = 0, b_wins = 0, b_er = 1, b_ec = 1;
    initial forever begin
        @(negedge clk);
        if (!b_reset) begin
            if (b_req) b_reads++;
            if (b_wvalid && b_wready) begin
                int ea;
                ea = b_er * BW + b_ec;
                check("big_win", {b_waddr, b_wdata}, {AW'(ea), exp_win_b(ea)});
                b_wins++;
                b_ec++;
                if (b_ec > BW - 2) begin
                    b_ec = 1;
                    b_er++;
                end
            end
        end
    end

    task automatic start_frame();
        s_reset  = 1'b1;
        s_gready = 1'b1;
        s_wready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_q.delete(); req_cyc.delete(); acc_addr.delete(); acc_cyc.delete();
        vstart.delete(); acc_data.delete();
        viol = 0; stall_viol = 0; fin_cyc = -1;
        s_reset = 1'b0;
    endtask

    task automatic wait_finish(input string tag);
        int n;
        n = 0;
        while (fin_cyc < 0 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_finish_seen"}, 128'(fin_cyc >= 0), 128'(1));
    endtask

    task automatic check_frame(input string tag);
        int exp_a[6];
        int exp_r[$];
        int nbad;
        exp_a = '{6, 7, 8, 11, 12, 13};
        for (int r = 1; r <= SH - 2; r++) begin
            for (int dc = -1; dc <= 1; dc++)
                for (int dr = -1; dr <= 1; dr++)
                    exp_r.push_back((r + dr) * SW + 1 + dc);
            for (int c = 2; c <= SW - 2; c++)
                for (int dr = -1; dr <= 1; dr++)
                    exp_r.push_back((r + dr) * SW + c + 1);
        end
        check({tag, "_nwin"}, acc_addr.size(), 6);
        for (int i = 0; i < 6 && i < acc_addr.size(); i++)
            check({tag, "_win"}, {acc_addr[i], acc_data[i]}, {exp_a[i], exp_win_s(exp_a[i])});
        nbad = 0;
        for (int i = 0; i < exp_r.size() && i < req_q.size(); i++)
            if (req_q[i] != exp_r[i]) nbad++;
        check({tag, "_nreq"}, req_q.size(), 30);
        check({tag, "_req_seq"}, nbad, 0);
        check({tag, "_req_not_ready"}, viol, 0);
        if (acc_cyc.size() > 0)
            check({tag, "_fin_cycle"}, fin_cyc, acc_cyc[acc_cyc.size()-1] + 1);
        check({tag, "_busy_fin"}, {s_busy, s_finish}, 2'b01);
    endtask

    initial begin
        int n;
        int acc_off[6];
        acc_off = '{10, 15, 20, 31, 36, 41};
        s_reset = 1'b1; s_gready = 1'b1; s_wready = 1'b1;
        b_reset = 1'b1; b_gready = 1'b0; b_wready = 1'b1;
        for (int i = 0; i < 16384; i++) bmem[i] = 8'($urandom);

        // Reset state with both handshake inputs high
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {s_req, s_gaddr, s_wvalid, s_wdata, s_waddr, s_busy, s_finish}, '0);

        // 1: single frame, free-running handshakes
        start_frame();
        wait_finish("s1");
        check_frame("s1");
        check("s1_first_win", acc_data.size() > 0 ? acc_data[0] : '1, 72'h0c0b0a070605020100);
        if (req_cyc.size() > 0 && vstart.size() > 0) begin
            check("s1_fill_latency", vstart[0] - req_cyc[0], 10);
            check("s1_fin_rel", fin_cyc - req_cyc[0], 42);
            for (int i = 0; i < 6 && i < acc_cyc.size(); i++)
                check("s1_acc_cycle", acc_cyc[i] - req_cyc[0], acc_off[i]);
        end

        // 2: the slide at centre 7 fetches only the new right column
        if (req_q.size() >= 12 && vstart.size() >= 2 && acc_data.size() >= 2) begin
            check("s2_slide_addrs", {req_q[9], req_q[10], req_q[11]}, {32'd3, 32'd8, 32'd13});
            check("s2_slide_latency", vstart[1] - req_cyc[9], 4);
            check("s2_slide_win", acc_data[1], 72'h0d0c0b080706030201);
        end else begin
            check("s2_logs_present", 0, 1);
        end

        // 3: hold win_ready low for 7 cycles on the second window
        start_frame();
        n = 0;
        while (acc_addr.size() < 1 && n < 100) begin @(posedge clk); #1; n++; end
        check("s3_wait_acc0", 128'(acc_addr.size() >= 1), 128'(1));
        s_wready = 1'b0;
        n = 0;
        while (vstart.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
        check("s3_wait_valid1", 128'(vstart.size() >= 2), 128'(1));
        repeat (6) @(posedge clk);
        #1;
        s_wready = 1'b1;
        wait_finish("s3");
        check_frame("s3");
        check("s3_hold_stable", stall_viol, 0);
        check("s3_nvalid", vstart.size(), 6);
        if (acc_cyc.size() >= 2 && vstart.size() >= 2 && req_cyc.size() > 0) begin
            check("s3_accept_delay", acc_cyc[1] - vstart[1], 7);
            check("s3_fin_rel", fin_cyc - req_cyc[0], 49);
        end

        // 4: gray_ready low for 3 cycles at FILL fetch 4
        start_frame();
        n = 0;
        while (req_q.size() < 4 && n < 100) begin @(posedge clk); #1; n++; end
        check("s4_wait_req3", 128'(req_q.size() >= 4), 128'(1));
        s_gready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        s_gready = 1'b1;
        wait_finish("s4");
        check_frame("s4");
        if (req_cyc.size() >= 5 && vstart.size() > 0) begin
            check("s4_req_gap", req_cyc[4] - req_cyc[3], 4);
            check("s4_fill_latency", vstart[0] - req_cyc[0], 13);
            check("s4_fin_rel", fin_cyc - req_cyc[0], 45);
        end

        // 5: reset in the middle of the first slide, then a clean frame
        start_frame();
        n = 0;
        while (acc_addr.size() < 1 && n < 100) begin @(posedge clk); #1; n++; end
        check("s5_wait_acc0", 128'(acc_addr.size() >= 1), 128'(1));
        @(posedge clk);
        #1;
        s_reset = 1'b1;
        #1;
        check("s5_reset_outs", {s_req, s_gaddr, s_wvalid, s_wdata, s_waddr, s_busy, s_finish}, '0);
        @(posedge clk);
        #1;
        check("s5_reset_hold", {s_req, s_gaddr, s_wvalid, s_wdata, s_waddr, s_busy, s_finish}, '0);
        start_frame();
        wait_finish("s5");
        check_frame("s5");

        // 6: full default-size frame against the scoreboard
        s_reset = 1'b1;
        b_gready = 1'b1;
        @(posedge clk);
        #1;
        b_reset = 1'b0;
        n = 0;
        while (!b_finish && n < 90000) begin @(posedge clk); #1; n++; end
        check("s6_finish_seen", b_finish, 1'b1);
        check("s6_windows", b_wins, (BW-2)*(BH-2));
        check("s6_reads", b_reads, (BH-2)*(9 + 3*(BW-3)));
        repeat (5) @(posedge clk);
        #1;
        check("s6_sticky", {b_busy, b_finish, b_req, b_wvalid}, 4'b0100);
        check("s6_reads_after", b_reads, 48384);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
